// File: rtl/gen_n_1_mux_hs.sv
// N:1 registered operand-select mux with req/ack handshake and output back-pressure.
// Inputs are snapshotted on acceptance; the result is held until the consumer takes it.
module gen_n_1_mux_hs #(
  parameter int PA_DATA_WIDTH = 32,
  parameter int PA_NUM_SRC    = 17,
  parameter int PA_SEL_WIDTH  = 5,
  parameter int PA_PIPE       = 0
) (
  input  logic                                clk,
  input  logic                                rst_b,
  input  logic                                req,
  input  logic [PA_SEL_WIDTH-1:0]             sel,
  input  logic [PA_NUM_SRC*PA_DATA_WIDTH-1:0] src_bus,
  input  logic                                out_ready,
  output logic [PA_DATA_WIDTH-1:0]            mux_out,
  output logic                                mux_ack,
  output logic                                mux_err,
  output logic                                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEL,
    S_HOLD
  } state_t;

  localparam logic [31:0] NUM_SRC_U = 32'(PA_NUM_SRC);

  state_t                     state_q, state_d;
  logic [PA_DATA_WIDTH-1:0]   out_q, out_d;
  logic                       err_q, err_d;
  logic [PA_DATA_WIDTH-1:0]   stage_data_q, stage_data_d;
  logic                       stage_err_q, stage_err_d;

  logic [PA_DATA_WIDTH-1:0]   pick [PA_NUM_SRC];
  logic [PA_DATA_WIDTH-1:0]   sel_data;
  logic                       sel_err;
  logic                       accept;

  // Full-width compare so high select bits can never alias onto a valid source.
  generate
    for (genvar gi = 0; gi < PA_NUM_SRC; gi++) begin : g_pick
      assign pick[gi] = (32'(sel) == gi) ? src_bus[gi*PA_DATA_WIDTH +: PA_DATA_WIDTH]
                                          : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < PA_NUM_SRC; i++) begin
      sel_data = sel_data | pick[i];
    end
  end

  assign sel_err = (32'(sel) >= NUM_SRC_U);
  assign busy    = (state_q == S_SEL) | ((state_q == S_HOLD) & ~out_ready);
  assign accept  = req & ~busy;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    err_d        = err_q;
    stage_data_d = stage_data_q;
    stage_err_d  = stage_err_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (PA_PIPE != 0) begin
            state_d      = S_SEL;
            stage_data_d = sel_data;
            stage_err_d  = sel_err;
          end else begin
            state_d = S_HOLD;
            out_d   = sel_data;
            err_d   = sel_err;
          end
        end
      end
      S_SEL: begin
        state_d = S_HOLD;
        out_d   = stage_data_q;
        err_d   = stage_err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      out_q        <= '0;
      err_q        <= 1'b0;
      stage_data_q <= '0;
      stage_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      err_q        <= err_d;
      stage_data_q <= stage_data_d;
      stage_err_q  <= stage_err_d;
    end
  end

  assign mux_out = out_q;
  assign mux_err = err_q;
  assign mux_ack = (state_q == S_HOLD);

endmodule

// File: tb/tb_gen_n_1_mux_hs.sv
// Bench for gen_n_1_mux_hs: one single-stage and one two-stage instance share clock,
// reset and sources; directed scenarios plus a randomized run against a due-time model.
module tb_gen_n_1_mux_hs;

  logic              clk;
  logic              rst_b;
  logic [31:0]       src_arr [17];
  logic [17*32-1:0]  src_bus;

  logic              req0, ordy0, ack0, err0, busy0;
  logic [4:0]        sel0;
  logic [31:0]       out0;
  logic              req1, ordy1, ack1, err1, busy1;
  logic [4:0]        sel1;
  logic [31:0]       out1;

  int checks   = 0;
  int failures = 0;

  gen_n_1_mux_hs #(.PA_DATA_WIDTH(32), .PA_NUM_SRC(17), .PA_SEL_WIDTH(5), .PA_PIPE(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .req(req0), .sel(sel0), .src_bus(src_bus),
    .out_ready(ordy0), .mux_out(out0), .mux_ack(ack0), .mux_err(err0), .busy(busy0)
  );

  gen_n_1_mux_hs #(.PA_DATA_WIDTH(32), .PA_NUM_SRC(17), .PA_SEL_WIDTH(5), .PA_PIPE(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .req(req1), .sel(sel1), .src_bus(src_bus),
    .out_ready(ordy1), .mux_out(out1), .mux_ack(ack1), .mux_err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_bus = '0;
    for (int i = 0; i < 17; i++) src_bus[i*32 +: 32] = src_arr[i];
  end

  function automatic logic [31:0] ref_val(input int s);
    if (s < 17) return src_arr[s];
    return 32'h0;
  endfunction

  task automatic init_src;
    for (int i = 0; i < 16; i++) src_arr[i] = 32'(i) * 32'h11111111;
    src_arr[16] = 32'hABABABAB;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    req0 = 0; req1 = 0; ordy0 = 1; ordy1 = 1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    #3;
    checks++; if (out0 !== 32'h0 || ack0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL por_dut0 got out=%h ack=%b err=%b busy=%b want all 0", out0, ack0, err0, busy0); end
    checks++; if (out1 !== 32'h0 || ack1 !== 1'b0 || err1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL por_dut1 got out=%h ack=%b err=%b busy=%b want all 0", out1, ack1, err1, busy1); end
    #9 rst_b = 1;
    tick();
    ordy0 = 0; req0 = 1; sel0 = 5'd3;
    tick();
    req0 = 0;
    checks++; if (ack0 !== 1'b1 || out0 !== 32'h33333333) begin failures++; $display("FAIL pre_reset_hold got ack=%b out=%h want 1 33333333", ack0, out0); end
    #1 rst_b = 0;
    #1;
    checks++; if (out0 !== 32'h0 || ack0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL async_reset got out=%h ack=%b err=%b busy=%b want all 0", out0, ack0, err0, busy0); end
    #3 rst_b = 1;
    $display("reset: async mid-cycle reset done");
    go_idle();
  endtask

  task automatic test_single;
    req0 = 1; sel0 = 5'd3; #1;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL single_busy got %b want 0", busy0); end
    tick();
    req0 = 0;
    checks++; if (out0 !== 32'h33333333 || ack0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL single_result got out=%h ack=%b err=%b want 33333333 1 0", out0, ack0, err0); end
    tick();
    checks++; if (ack0 !== 1'b0 || out0 !== 32'h33333333) begin failures++; $display("FAIL single_release got ack=%b out=%h want 0 33333333", ack0, out0); end
    $display("single: sel=3 out=%h", out0);
    go_idle();
  endtask

  task automatic test_back_to_back;
    int seq [3] = '{0, 1, 16};
    req0 = 1; sel0 = 5'(seq[0]);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out0 !== ref_val(seq[k]) || ack0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL b2b_%0d got out=%h ack=%b busy=%b want %h 1 0", k, out0, ack0, busy0, ref_val(seq[k])); end
      $display("b2b: sel=%0d out=%h ack=%b", seq[k], out0, ack0);
      if (k < 2) sel0 = 5'(seq[k+1]);
      else req0 = 0;
    end
    tick();
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL b2b_end_ack got %b want 0", ack0); end
    go_idle();
  endtask

  task automatic test_backpressure;
    ordy0 = 0; req0 = 1; sel0 = 5'd5;
    tick();
    req0 = 0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (out0 !== 32'h55555555 || ack0 !== 1'b1 || busy0 !== 1'b1) begin failures++; $display("FAIL bp_hold_%0d got out=%h ack=%b busy=%b want 55555555 1 1", k, out0, ack0, busy0); end
      if (k == 3) begin req0 = 1; sel0 = 5'd7; end
      if (k == 4) req0 = 0;
      tick();
    end
    ordy0 = 1; #1;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bp_ready_busy got %b want 0", busy0); end
    tick();
    checks++; if (ack0 !== 1'b0 || out0 !== 32'h55555555) begin failures++; $display("FAIL bp_release got ack=%b out=%h want 0 55555555", ack0, out0); end
    $display("backpressure: held 10 cycles, released ack=%b", ack0);
    go_idle();
  endtask

  task automatic test_snapshot_range;
    int ranges [3] = '{17, 31, 16};
    req0 = 1; sel0 = 5'd5;
    tick();
    req0 = 0; src_arr[5] = 32'hDEADBEEF;
    checks++; if (out0 !== 32'h55555555) begin failures++; $display("FAIL snap_pipe0 got %h want 55555555", out0); end
    src_arr[5] = 32'h55555555;
    go_idle();
    req1 = 1; sel1 = 5'd5;
    tick();
    req1 = 0; src_arr[5] = 32'h12345678;
    tick();
    checks++; if (out1 !== 32'h55555555 || ack1 !== 1'b1) begin failures++; $display("FAIL snap_pipe1 got out=%h ack=%b want 55555555 1", out1, ack1); end
    $display("snapshot: pipe1 out=%h", out1);
    src_arr[5] = 32'h55555555;
    go_idle();
    for (int k = 0; k < 3; k++) begin
      req0 = 1; sel0 = 5'(ranges[k]);
      tick();
      req0 = 0;
      checks++; if (out0 !== ref_val(ranges[k]) || err0 !== (ranges[k] >= 17) || ack0 !== 1'b1) begin failures++; $display("FAIL range_sel%0d got out=%h err=%b ack=%b want %h %b 1", ranges[k], out0, err0, ack0, ref_val(ranges[k]), ranges[k] >= 17); end
      $display("range: sel=%0d out=%h err=%b", ranges[k], out0, err0);
      tick();
    end
    go_idle();
  endtask

  task automatic test_pipe;
    req1 = 1; sel1 = 5'd16; #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL pipe_idle_busy got %b want 0", busy1); end
    tick();
    req1 = 0;
    checks++; if (ack1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL pipe_sel got ack=%b busy=%b want 0 1", ack1, busy1); end
    tick();
    checks++; if (ack1 !== 1'b1 || out1 !== 32'hABABABAB || busy1 !== 1'b0) begin failures++; $display("FAIL pipe_result got ack=%b out=%h busy=%b want 1 abababab 0", ack1, out1, busy1); end
    tick();
    checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL pipe_release got %b want 0", ack1); end
    $display("pipe: sel=16 out=%h", out1);
    req1 = 1; sel1 = 5'd2;
    tick();
    req1 = 0;
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL pipe_rst_pre got busy=%b want 1", busy1); end
    #1 rst_b = 0;
    #1;
    checks++; if (ack1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 32'h0) begin failures++; $display("FAIL pipe_rst got ack=%b busy=%b out=%h want 0 0 0", ack1, busy1, out1); end
    #3 rst_b = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ack1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL pipe_rst_after_%0d got ack=%b busy=%b want 0 0", k, ack1, busy1); end
    end
    $display("pipe: reset in SEL discarded result");
    go_idle();
  endtask

  // Model: an accepted request becomes visible after edge (accept + latency - 1) and
  // stays until an edge with out_ready; the last value persists once consumed.
  task automatic test_random;
    bit          m_ack [2];
    logic [31:0] m_out [2];
    bit          m_err [2];
    bit          p_v   [2];
    logic [31:0] p_d   [2];
    bit          p_e   [2];
    bit          acc   [2];
    bit          rdy   [2];
    logic [31:0] snap  [2];
    bit          snap_e[2];
    int          errs_before;
    errs_before = failures;
    #1 rst_b = 0;
    #1 rst_b = 1;
    for (int d = 0; d < 2; d++) begin
      m_ack[d] = 0; m_out[d] = '0; m_err[d] = 0; p_v[d] = 0; p_d[d] = '0; p_e[d] = 0;
    end
    tick();
    for (int n = 0; n < 400; n++) begin
      req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
      sel0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      sel1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      ordy0 = ($urandom_range(0, 3) != 0); ordy1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) src_arr[$urandom_range(0, 16)] = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        bit rq, bz, exp_bz;
        int sl;
        rq  = (d == 0) ? req0 : req1;
        sl  = (d == 0) ? int'(sel0) : int'(sel1);
        rdy[d] = (d == 0) ? ordy0 : ordy1;
        bz  = (d == 0) ? busy0 : busy1;
        exp_bz = p_v[d] || (m_ack[d] && !rdy[d]);
        checks++; if (bz !== exp_bz) begin failures++; $display("FAIL rand_busy dut%0d cyc%0d got %b want %b", d, n, bz, exp_bz); end
        acc[d] = rq && !exp_bz;
        snap[d] = ref_val(sl);
        snap_e[d] = (sl >= 17);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        logic [31:0] o;
        bit a, e;
        if (m_ack[d] && rdy[d]) m_ack[d] = 0;
        if (p_v[d]) begin m_ack[d] = 1; m_out[d] = p_d[d]; m_err[d] = p_e[d]; p_v[d] = 0; end
        if (acc[d]) begin
          if (d == 0) begin m_ack[d] = 1; m_out[d] = snap[d]; m_err[d] = snap_e[d]; end
          else begin p_v[d] = 1; p_d[d] = snap[d]; p_e[d] = snap_e[d]; end
        end
        o = (d == 0) ? out0 : out1;
        a = (d == 0) ? ack0 : ack1;
        e = (d == 0) ? err0 : err1;
        checks++; if (o !== m_out[d] || a !== m_ack[d] || e !== m_err[d]) begin failures++; $display("FAIL rand_out dut%0d cyc%0d got out=%h ack=%b err=%b want %h %b %b", d, n, o, a, e, m_out[d], m_ack[d], m_err[d]); end
      end
    end
    $display("random: 400 cycles, new failures=%0d", failures - errs_before);
    init_src();
    go_idle();
  endtask

  initial begin
    clk = 0; rst_b = 0;
    req0 = 0; sel0 = '0; ordy0 = 1;
    req1 = 0; sel1 = '0; ordy1 = 1;
    init_src();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_snapshot_range();
    test_pipe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
